// File: rtl/isp_raw_pattern_gen.sv
// DVP-style Bayer test-pattern source: emits href/vsync/raw frames with programmable
// blanking and four test patterns, for bring-up and self-test without a sensor.
module isp_raw_pattern_gen #(
  parameter int BITS        = 8,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 960,
  parameter int BAYER       = 0,
  parameter int HBLANK      = 160,
  parameter int VSYNC_LINES = 2,
  parameter int VBACK       = 20,
  parameter int VFRONT      = 8
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [1:0]      pattern,
  input  logic [BITS-1:0] flat_value,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic            busy,
  output logic            frame_done,
  output logic [15:0]     frame_cnt
);

  localparam int L           = WIDTH + HBLANK;
  localparam int TOTAL       = VSYNC_LINES + VBACK + HEIGHT + VFRONT;
  localparam int PIX_W       = $clog2(L);
  localparam int LINE_W      = $clog2(TOTAL);
  localparam int BAR_LEN     = WIDTH / 8;
  localparam int SUB_W       = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;
  localparam int ACT_FIRST   = VSYNC_LINES + VBACK;
  localparam int FRONT_FIRST = ACT_FIRST + HEIGHT;

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(L - 1);
  localparam logic [PIX_W-1:0]  PIX_WIDTH = PIX_W'(WIDTH);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(TOTAL - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(BAR_LEN - 1);
  localparam logic [1:0]        PHASE     = 2'(BAYER);
  localparam logic [BITS-1:0]   PIX_MAX   = {BITS{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [2:0]        bar_q, bar_d;
  logic              start_q, start_d;
  logic [1:0]        pat_q, pat_d;
  logic [BITS-1:0]   flat_q, flat_d;
  logic              frame_start, frame_end;

  logic              href_d;
  logic [BITS-1:0]   raw_d;
  logic [BITS-1:0]   pix_val;
  logic [31:0]       x_ext, y_ext;
  logic [1:0]        idx;
  logic              chan_on;

  // Line-number to region map; zero-length regions simply never match.
  function automatic state_t line_state(input logic [LINE_W-1:0] l);
    if (32'(l) < VSYNC_LINES)      return ST_VSYNC;
    else if (32'(l) < ACT_FIRST)   return ST_VBACK;
    else if (32'(l) < FRONT_FIRST) return ST_ACTIVE;
    else                           return ST_VFRONT;
  endfunction

  // Counters hold the position of the output cycle currently on the pins;
  // outputs are registered from the next position so both update together.
  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    state_d     = state_q;
    pix_d       = pix_q;
    line_d      = line_q;
    sub_d       = sub_q;
    bar_d       = bar_q;
    start_d     = 1'b0;
    pat_d       = pat_q;
    flat_d      = flat_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // One armed cycle between sampling enable and the first vsync cycle.
        start_d = enable & ~start_q;
        if (start_q) frame_start = 1'b1;
      end
      default: begin
        if (pix_q == PIX_LAST) begin
          pix_d = '0;
          if (line_q == LINE_LAST) begin
            frame_end = 1'b1;
            if (enable) frame_start = 1'b1;
            else        state_d     = ST_IDLE;
          end else begin
            line_d  = line_q + LINE_W'(1);
            state_d = line_state(line_d);
          end
        end else begin
          pix_d = pix_q + PIX_W'(1);
        end
      end
    endcase

    if (frame_start) begin
      state_d = ST_VSYNC;
      pix_d   = '0;
      line_d  = '0;
      pat_d   = pattern;
      flat_d  = flat_value;
    end

    // Colour-bar index tracked incrementally to avoid a divider by WIDTH/8.
    if (pix_d == '0) begin
      sub_d = '0;
      bar_d = '0;
    end else if (sub_q == SUB_LAST) begin
      sub_d = '0;
      bar_d = bar_q + 3'd1;
    end else begin
      sub_d = sub_q + SUB_W'(1);
    end
  end

  always_comb begin
    x_ext   = 32'(pix_d);
    y_ext   = 32'(line_d) - 32'(ACT_FIRST);
    href_d  = (state_d == ST_ACTIVE) && (pix_d < PIX_WIDTH);
    idx     = {y_ext[0], x_ext[0]} ^ PHASE;
    chan_on = 1'b0;
    pix_val = '0;

    unique case (idx)
      2'd0:    chan_on = ~bar_d[1];
      2'd3:    chan_on = ~bar_d[0];
      default: chan_on = ~bar_d[2];
    endcase

    unique case (pat_d)
      2'd0:    pix_val = chan_on ? PIX_MAX : '0;
      2'd1:    pix_val = BITS'(x_ext + y_ext);
      2'd2:    pix_val = flat_d;
      default: pix_val = (x_ext[3] ^ y_ext[3]) ? PIX_MAX : '0;
    endcase

    raw_d = href_d ? pix_val : '0;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      sub_q   <= '0;
      bar_q   <= '0;
      start_q <= 1'b0;
      pat_q   <= '0;
      flat_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      sub_q   <= sub_d;
      bar_q   <= bar_d;
      start_q <= start_d;
      pat_q   <= pat_d;
      flat_q  <= flat_d;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_href   <= 1'b0;
      out_vsync  <= 1'b0;
      out_raw    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      out_href   <= href_d;
      out_vsync  <= (state_d == ST_VSYNC);
      out_raw    <= raw_d;
      busy       <= (state_d != ST_IDLE);
      frame_done <= frame_end;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_isp_raw_pattern_gen.sv
// Directed bench for isp_raw_pattern_gen: small 8x4 instance for timing, patterns and
// reset behaviour, plus a 16x16 BGGR instance for colour-bar phase and checkerboard.
module tb_isp_raw_pattern_gen;

  localparam int L_A = 12;
  localparam int F_A = 84;
  localparam int L_B = 20;
  localparam int F_B = 380;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;

  logic        en_a = 1'b0;
  logic [1:0]  pat_a = '0;
  logic [7:0]  flat_a = '0;
  logic        href_a, vsync_a, busy_a, done_a;
  logic [7:0]  raw_a;
  logic [15:0] cnt_a;

  logic        en_b = 1'b0;
  logic [1:0]  pat_b = '0;
  logic [7:0]  flat_b = '0;
  logic        href_b, vsync_b, busy_b, done_b;
  logic [7:0]  raw_b;
  logic [15:0] cnt_b;

  always #5 pclk = ~pclk;

  isp_raw_pattern_gen #(
    .BITS(8), .WIDTH(8), .HEIGHT(4), .BAYER(0), .HBLANK(4),
    .VSYNC_LINES(1), .VBACK(1), .VFRONT(1)
  ) u_dut_a (
    .pclk(pclk), .rst_n(rst_n), .enable(en_a), .pattern(pat_a), .flat_value(flat_a),
    .out_href(href_a), .out_vsync(vsync_a), .out_raw(raw_a),
    .busy(busy_a), .frame_done(done_a), .frame_cnt(cnt_a)
  );

  isp_raw_pattern_gen #(
    .BITS(8), .WIDTH(16), .HEIGHT(16), .BAYER(3), .HBLANK(4),
    .VSYNC_LINES(1), .VBACK(1), .VFRONT(1)
  ) u_dut_b (
    .pclk(pclk), .rst_n(rst_n), .enable(en_b), .pattern(pat_b), .flat_value(flat_b),
    .out_href(href_b), .out_vsync(vsync_b), .out_raw(raw_b),
    .busy(busy_b), .frame_done(done_b), .frame_cnt(cnt_b)
  );

  int vectors = 0;
  int fails   = 0;

  logic        o_href  [400];
  logic        o_vsync [400];
  logic        o_busy  [400];
  logic        o_done  [400];
  logic [7:0]  o_raw   [400];
  logic [15:0] o_cnt   [400];
  logic [7:0]  exp_row [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sets up inputs at a falling edge and returns at the falling edge of frame cycle 0.
  task automatic start_frame(input bit sel, input bit pulse, input logic [1:0] pat, input logic [7:0] flat);
    @(negedge pclk);
    if (!sel) begin en_a = 1'b1; pat_a = pat; flat_a = flat; end
    else      begin en_b = 1'b1; pat_b = pat; flat_b = flat; end
    @(negedge pclk);
    if (pulse) begin
      if (!sel) en_a = 1'b0;
      else      en_b = 1'b0;
    end
    @(negedge pclk);
  endtask

  // Records n output cycles starting at the current falling edge; optionally changes
  // pattern/flat after cycle chg_c and drops enable after cycle dis_c.
  task automatic capture(input bit sel, input int n, input int chg_c, input logic [1:0] chg_pat,
                         input logic [7:0] chg_flat, input int dis_c);
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge pclk);
      if (!sel) begin
        o_href[c] = href_a; o_vsync[c] = vsync_a; o_busy[c] = busy_a;
        o_done[c] = done_a; o_raw[c] = raw_a; o_cnt[c] = cnt_a;
      end else begin
        o_href[c] = href_b; o_vsync[c] = vsync_b; o_busy[c] = busy_b;
        o_done[c] = done_b; o_raw[c] = raw_b; o_cnt[c] = cnt_b;
      end
      if (c == chg_c) begin
        if (!sel) begin pat_a = chg_pat; flat_a = chg_flat; end
        else      begin pat_b = chg_pat; flat_b = chg_flat; end
      end
      if (c == dis_c) begin
        if (!sel) en_a = 1'b0;
        else      en_b = 1'b0;
      end
    end
  endtask

  // Frame geometry from the cycle number: one vsync line, one back-porch line, then h active lines.
  task automatic check_timing(input string tag, input int nfr, input int f_len, input int l_len,
                              input int w, input int h);
    for (int c = 0; c < nfr * f_len; c++) begin
      int p;
      int ln;
      int px;
      logic [4:0] e;
      logic [4:0] o;
      p  = c % f_len;
      ln = p / l_len;
      px = p % l_len;
      e  = {1'b1, (c > 0 && p == 0), (ln < 1), (ln >= 2 && ln < 2 + h && px < w), 1'b1};
      o  = {o_busy[c], o_done[c], o_vsync[c], o_href[c], (o_href[c] || o_raw[c] == 8'h00)};
      check($sformatf("%s c=%0d busy/done/vsync/href/rawzero", tag, c), 32'(o), 32'(e));
    end
  endtask

  task automatic check_row(input string tag, input int start, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s x=%0d", tag, i), 32'(o_raw[start + i]), 32'(exp_row[i]));
  endtask

  initial begin
    logic [31:0] sticky;

    // Reset and idle behaviour
    repeat (3) @(negedge pclk);
    check("reset a", 32'({href_a, vsync_a, raw_a, busy_a, done_a, cnt_a}), 32'h0);
    check("reset b", 32'({href_b, vsync_b, raw_b, busy_b, done_b, cnt_b}), 32'h0);
    rst_n = 1'b1;
    sticky = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk);
      sticky |= 32'({href_a, vsync_a, raw_a, busy_a, done_a, cnt_a});
    end
    check("idle 100 cycles", sticky, 32'h0);

    // Single pulse start, flat 0x5A
    start_frame(1'b0, 1'b1, 2'd2, 8'h5A);
    capture(1'b0, 86, -1, 2'd0, 8'h00, -1);
    check_timing("flat", 1, F_A, L_A, 8, 4);
    exp_row = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_row("flat y0", 24, 8);
    check_row("flat y1", 36, 8);
    check_row("flat y2", 48, 8);
    check_row("flat y3", 60, 8);
    check("flat end done",  32'(o_done[84]),  32'd1);
    check("flat end busy",  32'(o_busy[84]),  32'd0);
    check("flat end vsync", 32'(o_vsync[84]), 32'd0);
    check("flat end cnt",   32'(o_cnt[84]),   32'd1);
    check("flat done width", 32'(o_done[85]), 32'd0);

    // Continuous run, ramp; pattern changed mid-frame, enable dropped mid frame 2
    start_frame(1'b0, 1'b0, 2'd1, 8'h00);
    capture(1'b0, 170, 40, 2'd2, 8'h33, 100);
    check_timing("ramp", 2, F_A, L_A, 8, 4);
    for (int i = 0; i < 8; i++) exp_row[i] = 8'(i);
    check_row("ramp y0", 24, 8);
    for (int i = 0; i < 8; i++) exp_row[i] = 8'(2 + i);
    check_row("ramp y2", 48, 8);
    for (int i = 0; i < 8; i++) exp_row[i] = 8'(3 + i);
    check_row("ramp y3", 60, 8);
    check("back2back vsync", 32'(o_vsync[84]), 32'd1);
    check("back2back done",  32'(o_done[84]),  32'd1);
    check("back2back busy",  32'(o_busy[84]),  32'd1);
    check("back2back cnt",   32'(o_cnt[84]),   32'd2);
    for (int i = 0; i < 8; i++) exp_row[i] = 8'h33;
    check_row("frame2 flat y0", 108, 8);
    check_row("frame2 flat y3", 144, 8);
    check("frame2 end done",  32'(o_done[168]), 32'd1);
    check("frame2 end busy",  32'(o_busy[168]), 32'd0);
    check("frame2 end cnt",   32'(o_cnt[168]),  32'd3);

    // Colour bars, RGGB, width 8
    start_frame(1'b0, 1'b1, 2'd0, 8'h00);
    capture(1'b0, 86, -1, 2'd0, 8'h00, -1);
    check_timing("bars", 1, F_A, L_A, 8, 4);
    exp_row = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_row("bars rggb y0", 24, 8);
    check_row("bars rggb y2", 48, 8);
    exp_row = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_row("bars rggb y1", 36, 8);
    check("bars end cnt", 32'(o_cnt[84]), 32'd4);

    // Reset asserted at cycle 50 of a frame
    start_frame(1'b0, 1'b0, 2'd2, 8'hA5);
    capture(1'b0, 51, -1, 2'd0, 8'h00, -1);
    check("pre-reset href", 32'(o_href[50]), 32'd1);
    check("pre-reset raw",  32'(o_raw[50]),  32'hA5);
    check("pre-reset cnt",  32'(o_cnt[50]),  32'd4);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'({href_a, vsync_a, raw_a, busy_a, done_a, cnt_a}), 32'h0);
    @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    capture(1'b0, 86, -1, 2'd0, 8'h00, 85);
    check_timing("post-reset", 1, F_A, L_A, 8, 4);
    check("post-reset done",  32'(o_done[84]),  32'd1);
    check("post-reset vsync", 32'(o_vsync[84]), 32'd1);
    check("post-reset cnt",   32'(o_cnt[84]),   32'd1);
    repeat (100) @(negedge pclk);
    check("post-reset idle busy", 32'(busy_a), 32'd0);
    check("post-reset idle cnt",  32'(cnt_a),  32'd2);

    // Colour bars, BGGR, width 16
    start_frame(1'b1, 1'b1, 2'd0, 8'h00);
    capture(1'b1, 382, -1, 2'd0, 8'h00, -1);
    check_timing("bars16", 1, F_B, L_B, 16, 16);
    exp_row = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF,
                8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    check_row("bars bggr y0", 40, 16);
    exp_row = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00,
                8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    check_row("bars bggr y1", 60, 16);
    check("bars16 end done", 32'(o_done[380]), 32'd1);
    check("bars16 end busy", 32'(o_busy[380]), 32'd0);
    check("bars16 end cnt",  32'(o_cnt[380]),  32'd1);

    // Checkerboard, 16x16
    start_frame(1'b1, 1'b1, 2'd3, 8'h00);
    capture(1'b1, 382, -1, 2'd0, 8'h00, -1);
    exp_row = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_row("checker y0", 40, 16);
    check_row("checker y7", 180, 16);
    exp_row = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_row("checker y8", 200, 16);
    check_row("checker y15", 340, 16);
    check("checker end cnt", 32'(o_cnt[380]), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
